// File: rtl/ball_physics.sv
`default_nettype none
// ============================================================================
// Module   : ball_physics
// Purpose  : Per-frame ball motion, wall/paddle/brick reflection, brick-state
//            write stream to the renderer, lives and win/loss tracking.
// Revision : 1.0 - initial release
// ============================================================================
module ball_physics #(
  parameter int STEP  = 2,
  parameter int LIVES = 3
) (
  input  logic       CLK_50MH,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [9:0] paddle_pos,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       active_write_enable,
  output logic [5:0] active_position,
  output logic [1:0] active_data,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [9:0] STEP_V   = 10'(STEP);
  localparam logic [9:0] X_MAX    = 10'd632;
  localparam logic [9:0] Y_REST   = 10'd433;
  localparam logic [4:0] N_BRICKS = 5'd20;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_MOVE  = 3'd2,
    S_SCAN  = 3'd3,
    S_WRITE = 3'd4,
    S_LOST  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     state, state_next;
  logic       dx, dy;
  logic [4:0] scan_idx;
  logic [1:0] scan_row;
  logic [2:0] scan_col;
  logic [1:0] hits [0:19];
  logic [4:0] destroyed;

  // Combinational results of one MOVE step
  logic [9:0] move_x, move_y, idle_x;
  logic       move_dx, move_dy, move_miss;
  logic [9:0] brick_x0, brick_x1, brick_y0, brick_y1;
  logic       overlap, hit_now;
  logic [1:0] hit_next;

  // Paddle-following x while parked, clamped to the right edge
  always_comb begin
    idle_x = paddle_pos + 10'd46;
    if ({1'b0, paddle_pos} + 11'd46 > {1'b0, X_MAX}) idle_x = X_MAX;
  end

  // Next position and direction: walls first, then ceiling/paddle/miss
  always_comb begin
    move_x    = ball_x;
    move_y    = ball_y;
    move_dx   = dx;
    move_dy   = dy;
    move_miss = 1'b0;
    if (!dx) begin
      if (ball_x < STEP_V) begin
        move_x  = 10'd0;
        move_dx = 1'b1;
      end else begin
        move_x = ball_x - STEP_V;
      end
    end else begin
      if ({1'b0, ball_x} + {1'b0, STEP_V} > {1'b0, X_MAX}) begin
        move_x  = X_MAX;
        move_dx = 1'b0;
      end else begin
        move_x = ball_x + STEP_V;
      end
    end
    if (!dy) begin
      if (ball_y < STEP_V) begin
        move_y  = 10'd0;
        move_dy = 1'b1;
      end else begin
        move_y = ball_y - STEP_V;
      end
    end else begin
      move_y = ball_y + STEP_V;
      if (({1'b0, move_y} + 11'd7 >= 11'd441) && (move_y <= 10'd449) &&
          ({1'b0, move_x} + 11'd7 > {1'b0, paddle_pos}) &&
          ({1'b0, move_x} < {1'b0, paddle_pos} + 11'd100)) begin
        move_y  = Y_REST;
        move_dy = 1'b0;
        // Right half of the paddle sends the ball right
        move_dx = ({1'b0, move_x} + 11'd4 >= {1'b0, paddle_pos} + 11'd50);
      end else if (move_y > 10'd472) begin
        move_miss = 1'b1;
      end
    end
  end

  // Box of the brick currently under scan and overlap with the ball box
  always_comb begin
    brick_x0 = 10'd40 + 10'(scan_col) * 10'd120;
    brick_x1 = brick_x0 + 10'd80;
    brick_y0 = 10'd40 + 10'(scan_row) * 10'd50;
    brick_y1 = brick_y0 + 10'd30;
    overlap  = (ball_x <= brick_x1) && (ball_x + 10'd7 >= brick_x0) &&
               (ball_y <= brick_y1) && (ball_y + 10'd7 >= brick_y0);
    hit_now  = (state == S_SCAN) && (hits[scan_idx] != 2'd3) && overlap;
    hit_next = hits[scan_idx] + 2'd1;
  end

  // State register
  always_ff @(posedge CLK_50MH) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (launch) state_next = S_WAIT;
      S_WAIT:  if (frame_tick) state_next = S_MOVE;
      S_MOVE:  state_next = move_miss ? S_LOST : S_SCAN;
      S_SCAN: begin
        if (hit_now)                state_next = S_WRITE;
        else if (scan_idx == 5'd19) state_next = S_WAIT;
      end
      S_WRITE: state_next = (destroyed == N_BRICKS) ? S_DONE : S_WAIT;
      S_LOST:  state_next = (lives == 2'd1) ? S_DONE : S_IDLE;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // Ball, brick, strobe and score datapath
  always_ff @(posedge CLK_50MH) begin
    if (reset) begin
      ball_x              <= 10'd296;
      ball_y              <= Y_REST;
      dx                  <= 1'b1;
      dy                  <= 1'b0;
      scan_idx            <= 5'd0;
      scan_row            <= 2'd0;
      scan_col            <= 3'd0;
      destroyed           <= 5'd0;
      active_write_enable <= 1'b0;
      active_position     <= 6'd0;
      active_data         <= 2'd0;
      lives               <= 2'(LIVES);
      game_over           <= 1'b0;
      game_won            <= 1'b0;
      for (int i = 0; i < 20; i++) hits[i] <= 2'd0;
    end else begin
      active_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          ball_x <= idle_x;
          ball_y <= Y_REST;
          if (launch) begin
            dx <= 1'b1;
            dy <= 1'b0;
          end
        end
        S_MOVE: begin
          if (!move_miss) begin
            ball_x <= move_x;
            ball_y <= move_y;
            dx     <= move_dx;
            dy     <= move_dy;
          end
          scan_idx <= 5'd0;
          scan_row <= 2'd0;
          scan_col <= 3'd0;
        end
        S_SCAN: begin
          if (hit_now) begin
            hits[scan_idx]      <= hit_next;
            dy                  <= ~dy;
            active_write_enable <= 1'b1;
            active_position     <= {1'b0, scan_idx};
            active_data         <= hit_next;
            if (hit_next == 2'd3) destroyed <= destroyed + 5'd1;
          end else begin
            scan_idx <= scan_idx + 5'd1;
            if (scan_col == 3'd4) begin
              scan_col <= 3'd0;
              scan_row <= scan_row + 2'd1;
            end else begin
              scan_col <= scan_col + 3'd1;
            end
          end
        end
        S_WRITE: if (destroyed == N_BRICKS) game_won <= 1'b1;
        S_LOST: begin
          lives <= lives - 2'd1;
          if (lives == 2'd1) game_over <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ball_physics.md
# ball_physics

Game-logic stage directly upstream of the VGA renderer. Once per video frame it advances the ball, reflects it off the walls, the paddle and the bricks, and streams brick-state updates to the renderer's brick-state write port (`active_write_enable`, `active_position`, `active_data`). It also tracks lives and win/loss. It runs in the `CLK_50MH` domain, the same domain as the renderer's brick-state write port.

## Interface
- `STEP`, 2: pixels moved per frame on each axis (legal range 1..7).
- `LIVES`, 3: lives loaded at reset (legal range 1..3).
- `CLK_50MH`, in, 1: the only clock.
- `reset`, in, 1: synchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse at the start of vertical blank.
- `launch`, in, 1: level input; releases the ball from the paddle.
- `paddle_pos`, in, 10: left x of the paddle (paddle spans x `paddle_pos+1`..`paddle_pos+99`, y 441..449).
- `ball_x`, out, 10: top-left x of the 8×8 ball.
- `ball_y`, out, 10: top-left y of the 8×8 ball.
- `active_write_enable`, out, 1: one-cycle brick write strobe.
- `active_position`, out, 6: brick index, 0..19.
- `active_data`, out, 2: new hit count for that brick (3 = destroyed).
- `lives`, out, 2: remaining lives.
- `game_over`, out, 1: sticky; set when lives reach 0.
- `game_won`, out, 1: sticky; set when all 20 bricks are destroyed.

## Operation
**Brick layout**
- Brick i has row r = i/5 and column c = i%5.
- x range: 40+120c .. 120+120c. y range: 40+50r .. 70+50r. Both ranges are inclusive.
- A local hit-count array (20 × 2 bits) mirrors the renderer's brick state. All entries are 0 after reset.

**Direction registers**
- `dx`: 1 = right. `dy`: 1 = down.

**States**
- IDLE: `ball_x` = min(`paddle_pos`+46, 632) and `ball_y` = 433, updated every cycle.
  - `launch`=1 sets dx=1, dy=0 and moves to WAIT.
  - `frame_tick` is ignored in IDLE.
- WAIT: on `frame_tick`, go to MOVE.
- MOVE (1 cycle): nx = x±STEP, ny = y±STEP. Apply these checks in order:
  - Horizontal: if dx=0 and x<STEP, then nx=0 and dx←1. If dx=1 and x+STEP>632, then nx=632 and dx←0.
  - Vertical, moving up: if y<STEP, then ny=0 and dy←1.
  - Vertical, moving down, paddle hit: if ny+7≥441, ny≤449, nx+7>`paddle_pos` and nx<`paddle_pos`+100, then ny=433 and dy←0. Also dx←(nx+4 ≥ `paddle_pos`+50).
  - Vertical, moving down, miss: otherwise, if ny>472, go to LOST without updating position.
  - Register nx and ny into `ball_x`/`ball_y`, then go to SCAN with index 0.
- SCAN (1 brick per cycle, indices 0..19): a brick is hit when its count <3 and the ball box [x..x+7]×[y..y+7] overlaps the brick box (inclusive).
  - On the first hit: count←count+1, dy inverted, go to WRITE. At most one brick is hit per frame.
  - After index 19 with no hit: go to WAIT.
- WRITE (1 cycle): pulse `active_write_enable` with `active_position`=i and `active_data`=new count.
  - If the destroyed-brick total reaches 20: `game_won`←1, go to DONE.
  - Otherwise go to WAIT.
- LOST: lives←lives−1.
  - If the new value is 0: `game_over`←1, go to DONE.
  - Otherwise go to IDLE.
- DONE: ball frozen. Only `reset` exits.

**Arithmetic**
- All comparisons are 10-bit unsigned on values that cannot wrap. Subtraction is guarded by the x<STEP / y<STEP checks.

## Timing
**Reset values**
- `ball_x`=296, `ball_y`=433.
- `active_write_enable`=0, `active_position`=0, `active_data`=0.
- `lives`=LIVES, `game_over`=0, `game_won`=0.
- State IDLE, all hit counts 0, destroyed total 0.

**Latencies from `frame_tick` (cycle 0)**
- New position visible at cycle 2.
- Write strobe at cycle 3..22, at 3+i for a hit on brick i.
- Back in WAIT by cycle 23 at the latest. All activity finishes inside vertical blank.

**Strobe rules**
- `active_write_enable` is exactly 1 cycle.
- `active_position`/`active_data` are valid during the strobe and hold their values afterward.

**Boundary conditions**
- `frame_tick` outside WAIT is dropped.
- `launch` and `frame_tick` in the same IDLE cycle: launch only; the first move happens on the next tick.
- Wall and brick reflection in the same frame both apply.
- `reset` mid-SCAN/WRITE: no strobe is issued (or the strobe is cut), and all state returns to reset values on the next edge.

## Test plan
- Reset, `paddle_pos`=200 → `ball_x`=246, `ball_y`=433, `lives`=3, no strobe. Then `paddle_pos`=600 → `ball_x`=632.
- `paddle_pos`=200, `launch`, then one tick → `ball_x`=248, `ball_y`=431 at tick+2.
- `paddle_pos`=600, `launch`, then tick → `ball_x`=632, `ball_y`=431, dx=0. Next tick → `ball_x`=630.
- `paddle_pos`=54, `launch`, then 107 ticks → after tick 107 (x=314, y=219): strobe with position 17, data 1, exactly one pulse. The next frames move the ball downward.
- Repeat the hit scenario until brick 17 reaches data=3 → no further strobes for index 17. The ball then passes through its area.
- Ball missing the paddle three times → `lives` 3→2→1→0, then `game_over`=1 and `launch` is ignored.
- Assert `reset` at tick+5 during a hit frame → no strobe, and all outputs equal their reset values one cycle later.
